// File: rtl/bcd_to_c2_converter_if.sv
// Keypad-to-generator conversion bus: start/busy/done handshake, packed BCD in,
// binary frequency word and status flags out.
interface bcd_to_c2_converter_if #(
    parameter int N_DIGITS  = 7,
    parameter int OUT_WIDTH = 23
);
    logic                   start;
    logic [4*N_DIGITS-1:0]  input_BCD;
    logic                   busy;
    logic                   done;
    logic [OUT_WIDTH-1:0]   output_C2;
    logic                   overflow;
    logic                   err_digit;

    modport master (
        output start, input_BCD,
        input  busy, done, output_C2, overflow, err_digit
    );

    modport slave (
        input  start, input_BCD,
        output busy, done, output_C2, overflow, err_digit
    );
endinterface

// File: rtl/bcd_to_c2_converter.sv
// Sequential BCD-to-binary converter: one acc = acc*10 + digit step per clock,
// most significant digit first, with digit-error and saturation flags.
module bcd_to_c2_converter #(
    parameter int N_DIGITS  = 7,
    parameter int OUT_WIDTH = 23,
    parameter int ACC_WIDTH = OUT_WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_to_c2_converter_if.slave bus
);
    localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t                state, state_next;
    logic [4*N_DIGITS-1:0] shadow, shadow_next;
    logic [ACC_WIDTH-1:0]  acc, acc_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  err_latch, err_latch_next;
    logic                  busy_q, busy_next;
    logic                  done_q, done_next;
    logic [OUT_WIDTH-1:0]  result_q, result_next;
    logic                  overflow_q, overflow_next;
    logic                  err_digit_q, err_digit_next;
    logic                  any_bad;
    logic [3:0]            nibble;

    always_comb begin
        any_bad = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (bus.input_BCD[4*i +: 4] > 4'd9) any_bad = 1'b1;
        end
    end

    assign nibble = shadow[4*int'(cnt) +: 4];

    always_comb begin
        state_next     = state;
        shadow_next    = shadow;
        acc_next       = acc;
        cnt_next       = cnt;
        err_latch_next = err_latch;
        busy_next      = busy_q;
        done_next      = 1'b0;
        result_next    = result_q;
        overflow_next  = overflow_q;
        err_digit_next = err_digit_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    shadow_next    = bus.input_BCD;
                    acc_next       = '0;
                    cnt_next       = CNT_W'(N_DIGITS - 1);
                    err_latch_next = any_bad;
                    busy_next      = 1'b1;
                    state_next     = CONV;
                end
            end
            CONV: begin
                // x*10 as (x<<3)+(x<<1); accumulator is wide enough never to wrap
                acc_next = (acc << 3) + (acc << 1) + ACC_WIDTH'(nibble);
                cnt_next = cnt - CNT_W'(1);
                if (cnt == '0) state_next = FINISH;
            end
            FINISH: begin
                if (err_latch) begin
                    result_next    = '0;
                    err_digit_next = 1'b1;
                    overflow_next  = 1'b0;
                end else if (|acc[ACC_WIDTH-1:OUT_WIDTH]) begin
                    result_next    = '1;
                    overflow_next  = 1'b1;
                    err_digit_next = 1'b0;
                end else begin
                    result_next    = acc[OUT_WIDTH-1:0];
                    overflow_next  = 1'b0;
                    err_digit_next = 1'b0;
                end
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            acc         <= '0;
            cnt         <= '0;
            err_latch   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            err_digit_q <= 1'b0;
        end else begin
            state       <= state_next;
            shadow      <= shadow_next;
            acc         <= acc_next;
            cnt         <= cnt_next;
            err_latch   <= err_latch_next;
            busy_q      <= busy_next;
            done_q      <= done_next;
            result_q    <= result_next;
            overflow_q  <= overflow_next;
            err_digit_q <= err_digit_next;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.output_C2 = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.err_digit = err_digit_q;
endmodule
